reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Integer register file for the single-cycle RV32I core: 32 x XLEN registers, two read ports, one write port.
- Sits directly upstream of the ALU. RD1 drives SrcA. RD2 drives SrcB, through the immediate mux.
- Written at the end of each instruction by the writeback path (ALUResult, load data or PC+4).
- Also exposes a third, read-only debug port for bench and trace inspection.

Parameters:
- XLEN, 32, register and data width in bits.
- NUM_REGS, 32, number of architectural registers; x0 is included.
- BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to RD1/RD2; 0 = reads return the pre-write value.

Ports:
- clk  in  1  core clock; all writes occur on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A1  in  $clog2(NUM_REGS)  read address, port 1 (rs1).
- A2  in  $clog2(NUM_REGS)  read address, port 2 (rs2).
- A3  in  $clog2(NUM_REGS)  write address (rd).
- WD3  in  XLEN  write data.
- WE3  in  1  write enable.
- RD1  out  XLEN  read data, port 1; feeds ALU SrcA.
- RD2  out  XLEN  read data, port 2; feeds the SrcB mux.
- DbgAddr  in  $clog2(NUM_REGS)  debug read address.
- DbgData  out  XLEN  debug read data; combinational; never bypassed.
- WriteCount  out  32  number of committed writes to non-x0 registers since reset.

Behaviour:
- Reset: reset_n low asynchronously clears every register and WriteCount to 0, with no wait for a clock edge. While reset_n is low, RD1/RD2/DbgData read 0 and writes are ignored. Release is synchronised upstream; no internal synchroniser.
- Write: on the rising clk edge with WE3=1 and A3!=0, reg[A3] <= WD3 and WriteCount increments by 1.
- x0 writes: WE3=1 with A3=0 is discarded and WriteCount is unchanged.
- WriteCount wraps from 2^32-1 to 0 silently.
- Read: RD1 and RD2 are purely combinational from A1/A2, with zero-cycle latency. Address 0 always returns 0, whatever the storage contents.
- Bypass (BYPASS=1): if WE3=1, A3!=0 and A3==A1, then RD1=WD3 in the same cycle. RD2 uses the same rule against A2.
- No bypass (BYPASS=0): RD1/RD2 return the stored value; the new value becomes visible after the edge.
- Same-address reads: A1==A2 returns identical data on both ports.
- Debug port: DbgData shows stored contents only, never WD3. DbgAddr=0 returns 0.
- Storage: out-of-range addresses cannot occur when NUM_REGS is a power of two. If NUM_REGS < 2^width, an out-of-range read returns 0 and an out-of-range write is ignored.
- Control inputs: X on WE3 outside reset is an error, flagged by an assertion.
- Assertions: storage entry 0 is never nonzero; WriteCount changes only on clk edges outside reset.

Decomposition:
- riscv_pkg holds XLEN, NUM_REGS, REG_ADDR_W = $clog2(NUM_REGS), and the typedefs reg_addr_t and xlen_t. The ALU and decoder share these.
- No sub-module: the storage array, bypass muxes and counter live in one module.
- The read-mux-with-bypass is a function local to the module, used for both RD1 and RD2.

Test Plan:
- Reset: pulse reset_n low mid-cycle after writing x5=32'hDEADBEEF. Required: RD1 (A1=5) reads 0 immediately, without a clock edge, and WriteCount=0.
- Write/read: write x1=10 and x2=20 on consecutive edges, then set A1=1, A2=2. Required: RD1=10, RD2=20; driving these into the ALU with ADD gives 30; WriteCount=2.
- x0 protection: WE3=1, A3=0, WD3=32'hFFFFFFFF, then A1=0. Required: RD1=0, DbgData (DbgAddr=0)=0, WriteCount unchanged.
- Bypass (BYPASS=1): x3 holds 7; in the same cycle WE3=1, A3=3, WD3=99, A1=A2=3. Required: before the edge RD1=RD2=99 and DbgData(3)=7; after the edge DbgData=99.
- No bypass (BYPASS=0 build): repeat the bypass scenario. Required: RD1=7 before the edge and 99 after.
- Full sweep: write reg[i]=i*32'h01010101 for i=1..31, then read every address on all three ports. Required: all values match, x0=0, WriteCount=31.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths and types for the register file, ALU and decoder.
`default_nettype none

package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: 2R1W integer register file with optional write-to-read bypass,
// a never-bypassed debug read port and a committed-write counter. Rev 1.0
`default_nettype none

module reg_file #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int BYPASS   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_REGS)-1:0] A1,
  input  logic [$clog2(NUM_REGS)-1:0] A2,
  input  logic [$clog2(NUM_REGS)-1:0] A3,
  input  logic [XLEN-1:0]             WD3,
  input  logic                        WE3,
  output logic [XLEN-1:0]             RD1,
  output logic [XLEN-1:0]             RD2,
  input  logic [$clog2(NUM_REGS)-1:0] DbgAddr,
  output logic [XLEN-1:0]             DbgData,
  output logic [31:0]                 WriteCount
);
  import riscv_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [31:0]     write_count;
  logic            wr_en;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // x0 and out-of-range addresses read as zero; bypass only when enabled.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] val;
    val = '0;
    if (a != '0 && in_range(a)) begin
      if (BYPASS != 0 && we && a == wa) val = wd;
      else                              val = stored;
    end
    return val;
  endfunction

  assign wr_en = reset_n && WE3 && (A3 != '0) && in_range(A3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      write_count <= '0;
    end else if (wr_en) begin
      regs[A3]    <= WD3;
      write_count <= write_count + 32'd1;
    end
  end

  always_comb begin
    RD1     = read_port(A1, regs[A1], wr_en, A3, WD3);
    RD2     = read_port(A2, regs[A2], wr_en, A3, WD3);
    DbgData = (DbgAddr != '0 && in_range(DbgAddr)) ? regs[DbgAddr] : '0;
  end

  assign WriteCount = write_count;

  a_we3_known: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(WE3));
  a_x0_zero:   assert property (@(posedge clk) regs[0] == '0);
  a_wc_step:   assert property (@(posedge clk) disable iff (!reset_n)
                 (write_count == $past(write_count)) ||
                 (write_count == $past(write_count) + 32'd1) ||
                 (write_count == 32'd0));

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reg_file with bypass on and off side by side.
`default_nettype none

module tb_reg_file;
  import riscv_pkg::*;

  logic      clk = 1'b0;
  logic      reset_n;
  reg_addr_t a1, a2, a3, dbg_addr;
  xlen_t     wd3;
  logic      we3;
  xlen_t     rd1, rd2, dbg_data;
  xlen_t     nb_rd1, nb_rd2, nb_dbg_data;
  logic [31:0] wc, nb_wc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .RD1(rd1), .RD2(rd2), .DbgAddr(dbg_addr), .DbgData(dbg_data), .WriteCount(wc)
  );

  reg_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
    .RD1(nb_rd1), .RD2(nb_rd2), .DbgAddr(dbg_addr), .DbgData(nb_dbg_data), .WriteCount(nb_wc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input reg_addr_t a, input xlen_t d);
    @(negedge clk);
    we3 = 1'b1; a3 = a; wd3 = d;
    @(posedge clk);
    @(negedge clk);
    we3 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; dbg_addr = '0;
    #12;
    check("reset_rd1", rd1, 32'd0);
    check("reset_wc", wc, 32'd0);
    reset_n = 1'b1;

    // Asynchronous reset wipes a stored value without a clock edge.
    write_reg(5'd5, 32'hDEADBEEF);
    a1 = 5'd5; #1;
    check("pre_reset_x5", rd1, 32'hDEADBEEF);
    check("pre_reset_wc", wc, 32'd1);
    #1 reset_n = 1'b0; #1;
    check("async_reset_rd1", rd1, 32'd0);
    check("async_reset_wc", wc, 32'd0);
    check("async_reset_nb_wc", nb_wc, 32'd0);
    reset_n = 1'b1;

    // Basic write then read, summed as the ALU ADD would.
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd20);
    a1 = 5'd1; a2 = 5'd2; #1;
    check("rd1_x1", rd1, 32'd10);
    check("rd2_x2", rd2, 32'd20);
    check("alu_add", rd1 + rd2, 32'd30);
    check("wc_two", wc, 32'd2);

    // x0 writes are discarded and never bypassed.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a1 = 5'd0; dbg_addr = 5'd0; #1;
    check("x0_bypass_rd1", rd1, 32'd0);
    @(posedge clk); @(negedge clk); we3 = 1'b0; #1;
    check("x0_rd1", rd1, 32'd0);
    check("x0_dbg", dbg_data, 32'd0);
    check("x0_wc", wc, 32'd2);

    // Same-cycle write/read of x3: bypass build forwards, other does not.
    write_reg(5'd3, 32'd7);
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'd99; a1 = 5'd3; a2 = 5'd3; dbg_addr = 5'd3; #1;
    check("byp_rd1", rd1, 32'd99);
    check("byp_rd2", rd2, 32'd99);
    check("byp_dbg", dbg_data, 32'd7);
    check("nobyp_rd1", nb_rd1, 32'd7);
    check("nobyp_rd2", nb_rd2, 32'd7);
    check("nobyp_dbg", nb_dbg_data, 32'd7);
    @(posedge clk); @(negedge clk); we3 = 1'b0; #1;
    check("byp_dbg_after", dbg_data, 32'd99);
    check("nobyp_rd1_after", nb_rd1, 32'd99);
    check("wc_four", wc, 32'd4);

    // Full sweep after a fresh reset.
    do_reset();
    for (int i = 1; i < NUM_REGS; i++) write_reg(reg_addr_t'(i), xlen_t'(i) * 32'h01010101);
    for (int i = 0; i < NUM_REGS; i++) begin
      a1 = reg_addr_t'(i);
      a2 = reg_addr_t'(NUM_REGS - 1 - i);
      dbg_addr = reg_addr_t'(i);
      #1;
      check($sformatf("sweep_rd1_%0d", i), rd1, xlen_t'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_%0d", NUM_REGS - 1 - i), rd2,
            xlen_t'(NUM_REGS - 1 - i) * 32'h01010101);
      check($sformatf("sweep_dbg_%0d", i), dbg_data, xlen_t'(i) * 32'h01010101);
      check($sformatf("sweep_nb_rd1_%0d", i), nb_rd1, xlen_t'(i) * 32'h01010101);
    end
    check("sweep_wc", wc, 32'd31);
    check("sweep_nb_wc", nb_wc, 32'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
